// File: rtl/nibble_add_sequencer.sv
// nibble_add_sequencer
// Performs a (4*NIBBLES)-bit addition by driving an external registered 4-bit
// adder stage one nibble at a time, LSB first. Each returned carry is chained
// into the next nibble's carry-in. The S nibbles are assembled into a wide sum.
//
// Ports
//   clk, rst              clock (rising edge) and synchronous active-high reset
//   in_valid / in_ready   operand handshake (slave side); in_ready only in IDLE
//   a, b, cin             operands and carry into nibble 0
//   add_x, add_y, add_cin registered nibble operands driven to the adder stage
//   add_s, add_co         adder stage result, valid ADD_LAT cycles after inputs
//   out_valid / out_ready result handshake (master side)
//   sum, cout             assembled result, {cout, sum} = a + b + cin
//
// NIBBLES must be at least 2.
module nibble_add_sequencer #(
    parameter int unsigned NIBBLES = 4,
    parameter int unsigned ADD_LAT = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4*NIBBLES-1:0] a,
    input  logic [4*NIBBLES-1:0] b,
    input  logic                 cin,
    output logic [3:0]           add_x,
    output logic [3:0]           add_y,
    output logic                 add_cin,
    input  logic [3:0]           add_s,
    input  logic                 add_co,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4*NIBBLES-1:0] sum,
    output logic                 cout
);

    localparam int unsigned W  = 4 * NIBBLES;
    // Nibble 0 goes straight from the inputs to the adder, so only the upper
    // nibbles need to be kept.
    localparam int unsigned HW = W - 4;
    localparam int unsigned IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam int unsigned CW = (ADD_LAT > 0) ? $clog2(ADD_LAT + 1) : 1;

    localparam logic [IW-1:0] LastIdx = IW'(NIBBLES - 1);
    localparam logic [CW-1:0] LastCnt = CW'(ADD_LAT);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [HW-1:0]   a_hi_q, a_hi_d;
    logic [HW-1:0]   b_hi_q, b_hi_d;
    logic [3:0]      add_x_q, add_x_d;
    logic [3:0]      add_y_q, add_y_d;
    logic            add_cin_q, add_cin_d;
    logic [W-1:0]    sum_q, sum_d;
    logic            cout_q, cout_d;
    logic            out_valid_q, out_valid_d;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        a_hi_d      = a_hi_q;
        b_hi_d      = b_hi_q;
        add_x_d     = add_x_q;
        add_y_d     = add_y_q;
        add_cin_d   = add_cin_q;
        sum_d       = sum_q;
        cout_d      = cout_q;
        out_valid_d = out_valid_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    a_hi_d    = a[W-1:4];
                    b_hi_d    = b[W-1:4];
                    add_x_d   = a[3:0];
                    add_y_d   = b[3:0];
                    add_cin_d = cin;
                    idx_d     = '0;
                    cnt_d     = '0;
                    state_d   = StRun;
                end
            end

            StRun: begin
                if (cnt_q == LastCnt) begin
                    for (int n = 0; n < int'(NIBBLES); n++) begin
                        if (idx_q == IW'(n)) begin
                            sum_d[4*n +: 4] = add_s;
                        end
                    end
                    if (idx_q == LastIdx) begin
                        cout_d      = add_co;
                        add_x_d     = '0;
                        add_y_d     = '0;
                        add_cin_d   = 1'b0;
                        out_valid_d = 1'b1;
                        state_d     = StDone;
                    end else begin
                        // Carry is forwarded together with the next operands,
                        // so no bubble is inserted between nibbles.
                        for (int n = 1; n < int'(NIBBLES); n++) begin
                            if (idx_q == IW'(n - 1)) begin
                                add_x_d = a_hi_q[4*(n-1) +: 4];
                                add_y_d = b_hi_q[4*(n-1) +: 4];
                            end
                        end
                        add_cin_d = add_co;
                        idx_d     = idx_q + IW'(1);
                        cnt_d     = '0;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            StDone: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end

            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            cnt_q       <= '0;
            a_hi_q      <= '0;
            b_hi_q      <= '0;
            add_x_q     <= '0;
            add_y_q     <= '0;
            add_cin_q   <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            a_hi_q      <= a_hi_d;
            b_hi_q      <= b_hi_d;
            add_x_q     <= add_x_d;
            add_y_q     <= add_y_d;
            add_cin_q   <= add_cin_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            out_valid_q <= out_valid_d;
        end
    end

    // in_ready is gated by rst so it reads 0 throughout any reset cycle.
    assign in_ready  = (state_q == StIdle) && !rst;
    assign add_x     = add_x_q;
    assign add_y     = add_y_q;
    assign add_cin   = add_cin_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign out_valid = out_valid_q;

endmodule

// File: doc/nibble_add_sequencer.md
# nibble_add_sequencer

Sequencer that performs a (4·NIBBLES)-bit addition by driving the registered 4-bit ripple-adder stage one nibble at a time, LSB first. It sits directly upstream of that stage: it supplies X/Y/Cin, chains each returned Co into the next nibble's Cin, and assembles the registered S nibbles into a wide sum. The operand side is a valid/ready slave and the result side is a valid/ready master, with one operation in flight at a time.

## Interface
- NIBBLES, 4: number of 4-bit slices; the operand width is 4·NIBBLES (16 by default).
- ADD_LAT, 2: number of cycles from the first cycle the adder stage sees its inputs to the cycle its S/Co outputs are valid. This is 2 for the input-register plus output-register stage.

- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  operand pair offered.
- in_ready  out  1  high only in IDLE and not in reset.
- a  in  4·NIBBLES  operand A.
- b  in  4·NIBBLES  operand B.
- cin  in  1  carry into nibble 0.
- add_x  out  4  nibble of A driven to the adder stage X (registered).
- add_y  out  4  nibble of B driven to the adder stage Y (registered).
- add_cin  out  1  carry driven to the adder stage Cin (registered).
- add_s  in  4  adder stage S.
- add_co  in  1  adder stage Co.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- sum  out  4·NIBBLES  assembled sum.
- cout  out  1  carry out of the top nibble.

## Operation
- There are three states: IDLE, RUN and DONE.
- IDLE:
  - in_ready is 1.
  - On the edge where in_valid && in_ready, capture a, b and cin into internal registers.
  - On that same edge, load add_x=a[3:0], add_y=b[3:0] and add_cin=cin.
  - Clear the nibble index and the wait counter, then go to RUN.
- RUN:
  - add_x, add_y and add_cin are held constant for ADD_LAT+1 cycles per nibble.
  - The wait counter counts 0..ADD_LAT.
  - On the edge where the counter equals ADD_LAT, write add_s into sum[4i+3:4i].
  - On that same edge, if i < NIBBLES-1: load the next nibble of A/B, set add_cin <= add_co, increment i and clear the counter.
  - On that same edge, if i == NIBBLES-1: set cout <= add_co, drive add_x, add_y and add_cin to 0, assert out_valid and go to DONE.
- DONE:
  - sum, cout and out_valid are held stable.
  - in_valid is ignored.
  - On the edge where out_valid && out_ready, clear out_valid and go to IDLE. sum and cout keep their last values.
- Arithmetic:
  - {cout,sum} = a + b + cin, exact over 4·NIBBLES+1 bits.
  - There is no saturation. Wrap-around is expressed only through cout.
- Reset (rst=1 at an edge):
  - State goes to IDLE, and i and the wait counter go to 0.
  - add_x, add_y, add_cin, sum, cout and out_valid all go to 0.
  - in_ready is 0 during any cycle in which rst is high.
  - An operation in progress is discarded, and no out_valid is produced for it.
- The adder stage's active-low reset is driven from ~rst at integration. Its reset therefore coincides with this block's reset.

## Timing
- Acceptance edge E0 (the in_valid && in_ready edge).
- Nibble i is sampled at edge E0 + (i+1)(ADD_LAT+1).
- out_valid first becomes high after edge E0 + NIBBLES·(ADD_LAT+1). With the defaults this is E0+12.
- Minimum throughput is one operation every NIBBLES·(ADD_LAT+1)+2 cycles, given out_ready=1:
  - 1 cycle in DONE,
  - 1 cycle in IDLE.
- in_ready is 0 from the cycle after E0 until the cycle after the output handshake.
- A carry produced by nibble i reaches add_cin in the same cycle that nibble i+1's operands appear. There is no extra bubble.
- Reset values:
  - in_ready=0 while rst is high, and 1 on the first cycle after rst falls.
  - All other outputs are 0.

## Test plan
- a=0x1234, b=0x4321, cin=0: requires sum=0x5555 and cout=0, with out_valid rising exactly 12 cycles after acceptance. Check add_x sequences 4,3,2,1 with 3 cycles per nibble.
- a=0xFFFF, b=0x0001, cin=0: requires add_cin to be 1 for nibbles 1–3, with sum=0x0000 and cout=1. This exercises the full carry chain.
- a=0xFFFF, b=0xFFFF, cin=1: requires sum=0xFFFF and cout=1.
- Backpressure with out_ready=0 for 5 cycles after out_valid, while a new in_valid is pending:
  - sum, cout and out_valid must be held.
  - in_ready must stay 0.
  - The pending operand must be accepted exactly 1 cycle after the handshake cycle.
- rst pulse at cycle 5 of an operation:
  - The next cycle must show out_valid=0, add_x/add_y/add_cin=0, sum=0 and cout=0.
  - A following operation a=0x00FF, b=0x0001 must produce 0x0100 with cout=0.
- Back-to-back operations with out_ready tied to 1 and in_valid always high: require one result every 14 cycles, each equal to a+b+cin from the reference model.
